sram_1rw_valrdy: RTL and testbench
==================================

SRAM_1RW_VALRDY -- requirements
Module: sram_1rw_valrdy

Interface
REQ-001 SHALL have parameter p_data_nbits, default 32: word width in bits (1..256).
REQ-002 SHALL have parameter p_num_entries, default 64: number of words (>=2, need not be a power of 2).
REQ-003 SHALL have parameter p_read_latency, default 1: cycles from request accept to response valid (legal values 1 or 2).
REQ-004 SHALL have parameter p_resp_depth, default 2: response buffer entries (>=1).
REQ-005 SHALL define local constants c_addr_nbits = $clog2(p_num_entries) and c_data_nbytes = ceil(p_data_nbits/8).
REQ-006 SHALL have port: clk  input  1  clock; all state changes on the rising edge.
REQ-007 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port: req_val  input  1  request valid.
REQ-009 SHALL have port: req_rdy  output  1  request ready.
REQ-010 SHALL have port: req_type  input  1  0=read, 1=write.
REQ-011 SHALL have port: req_addr  input  c_addr_nbits  word address.
REQ-012 SHALL have port: req_data  input  p_data_nbits  write data.
REQ-013 SHALL have port: req_byte_en  input  c_data_nbytes  per-byte write enable.
REQ-014 SHALL have port: resp_val  output  1  response valid.
REQ-015 SHALL have port: resp_rdy  input  1  response ready.
REQ-016 SHALL have port: resp_type  output  1  echo of req_type.
REQ-017 SHALL have port: resp_err  output  1  address out of range.
REQ-018 SHALL have port: resp_data  output  p_data_nbits  read data; 0 for writes and errors.
REQ-019 SHALL have port: init_done  output  1  array zero-fill complete.

Function
REQ-020 SHALL implement an FSM with states INIT and RUN; leaving reset enters INIT.
REQ-021 In INIT, the FSM SHALL write zero to one entry per cycle, entries 0..p_num_entries-1 in order, then enter RUN; INIT SHALL last exactly p_num_entries cycles.
REQ-022 init_done SHALL be 1 only in RUN.
REQ-023 req_rdy SHALL equal RUN && (in-flight + buffered responses < p_resp_depth), with no combinational path from req_val to req_rdy.
REQ-024 A request SHALL be accepted on a rising edge where req_val && req_rdy.
REQ-025 A write SHALL update byte i at the accept edge iff req_byte_en[i]; the top partial byte SHALL update only its p_data_nbits-8*(c_data_nbytes-1) bits.
REQ-026 A request accepted at edge N SHALL present resp_val=1 after edge N+p_read_latency (writes included), given an empty buffer.
REQ-027 A read SHALL sample the array at the accept edge, so a read accepted one cycle after a write to the same address returns the new data.
REQ-028 For req_addr >= p_num_entries, a write SHALL be dropped and a read SHALL return 0; both SHALL respond with resp_err=1.
REQ-029 Responses SHALL be returned in acceptance order; resp_* SHALL hold stable while resp_val && !resp_rdy.
REQ-030 Enqueue and dequeue in the same cycle SHALL be legal; credit accounting SHALL prevent buffer overflow.
REQ-031 With resp_rdy=1 and p_resp_depth >= p_read_latency+1, the block SHALL sustain one request per cycle.
REQ-032 Outside reset, the block SHALL assert that req_val and resp_rdy are not X, and that req_type, req_addr and req_byte_en are not X when req_val=1.

Reset
REQ-033 While reset==0 at a rising edge, the block SHALL set FSM=INIT, init counter=0, clear pipeline valids, empty the buffer and zero the credits.
REQ-034 During and immediately after reset, outputs SHALL be req_rdy=0, resp_val=0, init_done=0, resp_err=0, resp_data=0.
REQ-035 Reset mid-operation SHALL discard all in-flight and buffered responses; reset mid-INIT SHALL restart zero-fill at entry 0.
REQ-036 The storage array SHALL have no reset of its own; its contents SHALL be defined only by INIT.

Structure
REQ-037 A shared header SHALL hold the req_type encodings (READ=0, WRITE=1) and the FSM state encodings.
REQ-038 The response buffer SHALL be a sub-module sram_resp_queue: a parametrised FIFO (width, depth) with a count output.

Verification
REQ-039 Config 64 entries; reset low 1 cycle -> init_done rises exactly 64 cycles after release, req_rdy=0 until then; read addr 5 -> resp_data 0, resp_err 0.
REQ-040 Write addr 3 = 0xdeadbeef (be 4'b1111), write addr 3 = 0x00000011 (be 4'b0001), read addr 3 -> 0xdeadbe11; resp_type sequence 1,1,0.
REQ-041 Latency 2, depth 3, resp_rdy=1, 8 back-to-back reads -> first resp_val 2 cycles after first accept, then 8 consecutive responses in order.
REQ-042 resp_rdy=0, depth 2 -> req_rdy drops after 2 accepts, resp_data stable; raising resp_rdy drains in order and restores req_rdy.
REQ-043 Config 48 entries: read addr 50 -> resp_err=1, data 0; write addr 50 -> resp_err=1, all entries unchanged.
REQ-044 reset asserted with 2 reads in flight -> resp_val=0 from the next cycle, no stale responses, full re-init follows.

Source files
------------

// File: rtl/sram_1rw_valrdy_pkg.sv
// Shared encodings for the single-port SRAM with valid/ready request and response channels.
package sram_1rw_valrdy_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

   // A one-entry ring still needs a one-bit pointer.
   function automatic int ptr_nbits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_1rw_valrdy_resp_queue.sv
// Response FIFO: ring buffer of any depth, registered head, occupancy count.
module sram_resp_queue
   import sram_1rw_valrdy_pkg::*;
#(
   parameter int  p_width     = 34,
   parameter int  p_depth     = 2,
   localparam int c_cnt_nbits = $clog2(p_depth + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_val,
   input  logic [p_width-1:0]     enq_data,
   output logic                   deq_val,
   input  logic                   deq_rdy,
   output logic [p_width-1:0]     deq_data,
   output logic [c_cnt_nbits-1:0] count
);

   localparam int c_ptr_nbits = ptr_nbits(p_depth);
   localparam logic [c_ptr_nbits-1:0] c_last_ptr = c_ptr_nbits'(p_depth - 1);

   logic [p_width-1:0]     slots [0:(2**c_ptr_nbits)-1];
   logic [c_ptr_nbits-1:0] rd_ptr;
   logic [c_ptr_nbits-1:0] wr_ptr;
   logic                   deq_fire;

   function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
      return (p == c_last_ptr) ? '0 : p + c_ptr_nbits'(1);
   endfunction

   assign deq_val  = (count != '0);
   assign deq_fire = deq_val && deq_rdy;
   assign deq_data = slots[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq_val)  wr_ptr <= ptr_inc(wr_ptr);
         if (deq_fire) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + c_cnt_nbits'(enq_val) - c_cnt_nbits'(deq_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (enq_val) slots[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/sram_1rw_valrdy.sv
// Single-port SRAM behind val/rdy channels: zero-fill on reset, byte-enabled writes,
// 1- or 2-cycle read pipeline feeding a credit-controlled in-order response FIFO.
module sram_1rw_valrdy
   import sram_1rw_valrdy_pkg::*;
#(
   parameter int  p_data_nbits   = 32,
   parameter int  p_num_entries  = 64,
   parameter int  p_read_latency = 1,
   parameter int  p_resp_depth   = 2,
   localparam int c_addr_nbits   = $clog2(p_num_entries),
   localparam int c_data_nbytes  = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_val,
   output logic                     req_rdy,
   input  logic                     req_type,
   input  logic [c_addr_nbits-1:0]  req_addr,
   input  logic [p_data_nbits-1:0]  req_data,
   input  logic [c_data_nbytes-1:0] req_byte_en,
   output logic                     resp_val,
   input  logic                     resp_rdy,
   output logic                     resp_type,
   output logic                     resp_err,
   output logic [p_data_nbits-1:0]  resp_data,
   output logic                     init_done
);

   localparam int c_entry_nbits = p_data_nbits + 2;
   localparam int c_cnt_nbits   = $clog2(p_resp_depth + 1);
   localparam int c_occ_nbits   = $clog2(p_resp_depth + 2) + 1;
   localparam int c_addr_w1     = c_addr_nbits + 1;
   localparam logic [c_addr_nbits-1:0] c_last_addr = c_addr_nbits'(p_num_entries - 1);
   localparam logic [c_addr_w1-1:0]    c_num_ent   = c_addr_w1'(p_num_entries);
   localparam logic [c_occ_nbits-1:0]  c_depth     = c_occ_nbits'(p_resp_depth);

   logic [p_data_nbits-1:0] mem [0:p_num_entries-1];

   state_e                    state, state_next;
   logic [c_addr_nbits-1:0]   init_addr, init_addr_next;

   logic                      req_fire;
   logic                      req_oor;
   logic [p_data_nbits-1:0]   byte_mask;
   logic [p_data_nbits-1:0]   rd_word;
   logic                      mem_we;
   logic [c_addr_nbits-1:0]   mem_waddr;
   logic [p_data_nbits-1:0]   mem_wdata;
   logic [p_data_nbits-1:0]   mem_wmask;

   logic                      vld_p1;
   logic                      vld_p2;
   logic [c_entry_nbits-1:0]  entry_p1;
   logic                      enq_val;
   logic [c_entry_nbits-1:0]  enq_entry;
   logic                      q_val;
   logic [c_entry_nbits-1:0]  q_entry;
   logic [c_cnt_nbits-1:0]    q_count;
   logic                      resp_fire;
   logic [c_occ_nbits-1:0]    occupancy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_INIT;
         init_addr <= '0;
      end else begin
         state     <= state_next;
         init_addr <= init_addr_next;
      end
   end

   always_comb begin
      state_next     = state;
      init_addr_next = init_addr;
      init_done      = 1'b0;
      case (state)
         ST_INIT: begin
            init_addr_next = init_addr + c_addr_nbits'(1);
            if (init_addr == c_last_addr) begin
               state_next     = ST_RUN;
               init_addr_next = '0;
            end
         end
         ST_RUN:  init_done = 1'b1;
         default: state_next = ST_INIT;
      endcase
   end

   // Credits cover everything accepted but not yet handed out; a same-cycle dequeue frees one.
   assign resp_fire = q_val && resp_rdy;
   assign occupancy = c_occ_nbits'(q_count) + c_occ_nbits'(vld_p1) + c_occ_nbits'(vld_p2);
   assign req_rdy   = (state == ST_RUN) && (occupancy < c_depth + c_occ_nbits'(resp_fire));
   assign req_fire  = req_val && req_rdy;
   assign req_oor   = ({1'b0, req_addr} >= c_num_ent);
   assign rd_word   = (req_type == REQ_READ && !req_oor) ? mem[req_addr] : '0;

   always_comb begin
      byte_mask = '0;
      for (int i = 0; i < p_data_nbits; i++) byte_mask[i] = req_byte_en[i/8];
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = init_addr;
      mem_wdata = '0;
      mem_wmask = '1;
      if (state == ST_INIT) begin
         mem_we = reset;
      end else if (req_fire && req_type == REQ_WRITE && !req_oor) begin
         mem_we    = reset;
         mem_waddr = req_addr;
         mem_wdata = req_data;
         mem_wmask = byte_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
   end

   // p1: array sampled at the accept edge
   always_ff @(posedge clk) begin
      if (!reset) vld_p1 <= 1'b0;
      else        vld_p1 <= req_fire;
   end

   always_ff @(posedge clk) begin
      if (req_fire) entry_p1 <= {req_type, req_oor, rd_word};
   end

   // p2: optional extra read stage
   if (p_read_latency >= 2) begin : g_lat2
      logic [c_entry_nbits-1:0] entry_p2;

      always_ff @(posedge clk) begin
         if (!reset) vld_p2 <= 1'b0;
         else        vld_p2 <= vld_p1;
      end

      always_ff @(posedge clk) begin
         if (vld_p1) entry_p2 <= entry_p1;
      end

      assign enq_val   = vld_p2;
      assign enq_entry = entry_p2;
   end else begin : g_lat1
      assign vld_p2    = 1'b0;
      assign enq_val   = vld_p1;
      assign enq_entry = entry_p1;
   end

   sram_resp_queue #(
      .p_width (c_entry_nbits),
      .p_depth (p_resp_depth)
   ) u_resp_queue (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (enq_val),
      .enq_data (enq_entry),
      .deq_val  (q_val),
      .deq_rdy  (resp_rdy),
      .deq_data (q_entry),
      .count    (q_count)
   );

   assign resp_val = q_val;
   assign {resp_type, resp_err, resp_data} = q_val ? q_entry : '0;

   always @(posedge clk) begin
      if (reset) begin
         assert (!$isunknown(req_val));
         assert (!$isunknown(resp_rdy));
         if (req_val) assert (!$isunknown({req_type, req_addr, req_byte_en}));
      end
   end

endmodule

// File: tb/tb_sram_1rw_valrdy.sv
// Bench: two configurations (64x32 lat1 depth2, 48x32 lat2 depth3) against a queue/array model.
module tb_sram_1rw_valrdy;

   localparam int N_ENT [2] = '{64, 48};
   localparam int LAT   [2] = '{1, 2};
   localparam int DEP   [2] = '{2, 3};

   logic        clk = 1'b0;
   logic        rst_n      [2];
   logic        req_val    [2];
   logic        req_rdy    [2];
   logic        req_type   [2];
   logic [5:0]  req_addr   [2];
   logic [31:0] req_data   [2];
   logic [3:0]  req_be     [2];
   logic        resp_val   [2];
   logic        resp_rdy   [2];
   logic        resp_type  [2];
   logic        resp_err   [2];
   logic [31:0] resp_data  [2];
   logic        init_done  [2];

   always #5 clk = ~clk;

   sram_1rw_valrdy #(.p_data_nbits(32), .p_num_entries(64), .p_read_latency(1), .p_resp_depth(2)) u_dut0 (
      .clk(clk), .reset(rst_n[0]), .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_type(req_type[0]),
      .req_addr(req_addr[0]), .req_data(req_data[0]), .req_byte_en(req_be[0]), .resp_val(resp_val[0]),
      .resp_rdy(resp_rdy[0]), .resp_type(resp_type[0]), .resp_err(resp_err[0]), .resp_data(resp_data[0]),
      .init_done(init_done[0]));

   sram_1rw_valrdy #(.p_data_nbits(32), .p_num_entries(48), .p_read_latency(2), .p_resp_depth(3)) u_dut1 (
      .clk(clk), .reset(rst_n[1]), .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_type(req_type[1]),
      .req_addr(req_addr[1]), .req_data(req_data[1]), .req_byte_en(req_be[1]), .resp_val(resp_val[1]),
      .resp_rdy(resp_rdy[1]), .resp_type(resp_type[1]), .resp_err(resp_err[1]), .resp_data(resp_data[1]),
      .init_done(init_done[1]));

   typedef struct {
      logic        typ;
      logic        err;
      logic [31:0] data;
      int          when;
   } rsp_t;

   rsp_t        exp_q [2][$];
   rsp_t        obs_q [2][$];
   logic [31:0] mem_m [2][64];
   bit          run_m [2];
   int          init_m [2];
   bit          acc_s [2];
   bit          deq_s [2];
   int          cyc = 0;
   bit          started = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s[dut%0d] at cycle %0d: got 0x%0h, expected 0x%0h", nm, k, cyc, act, want);
      end
   endtask

   // Model update on every rising edge, using the decisions captured at the preceding falling edge.
   always @(posedge clk) begin
      cyc++;
      started = 1;
      for (int k = 0; k < 2; k++) begin
         rsp_t e;
         if (!rst_n[k]) begin
            exp_q[k].delete();
            run_m[k]  = 0;
            init_m[k] = 0;
         end else if (!run_m[k]) begin
            init_m[k]++;
            if (init_m[k] == N_ENT[k]) begin
               run_m[k] = 1;
               for (int a = 0; a < 64; a++) mem_m[k][a] = 32'h0;
            end
         end else begin
            if (deq_s[k]) void'(exp_q[k].pop_front());
            if (acc_s[k]) begin
               e.typ  = req_type[k];
               e.err  = (int'(req_addr[k]) >= N_ENT[k]);
               e.data = 32'h0;
               e.when = cyc + LAT[k];
               if (!e.err) begin
                  if (req_type[k]) begin
                     for (int b = 0; b < 4; b++)
                        if (req_be[k][b]) mem_m[k][req_addr[k]][8*b +: 8] = req_data[k][8*b +: 8];
                  end else begin
                     e.data = mem_m[k][req_addr[k]];
                  end
               end
               exp_q[k].push_back(e);
            end
         end
      end
   end

   // Compare DUT outputs with the model every falling edge.
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            bit ev;
            bit er;
            rsp_t o;
            ev = (exp_q[k].size() > 0) && (exp_q[k][0].when <= cyc);
            er = run_m[k] && ((exp_q[k].size() - ((ev && resp_rdy[k]) ? 1 : 0)) < DEP[k]);
            chk("init_done", k, init_done[k], run_m[k]);
            chk("req_rdy", k, req_rdy[k], er);
            chk("resp_val", k, resp_val[k], ev);
            if (ev) begin
               chk("resp_type", k, resp_type[k], exp_q[k][0].typ);
               chk("resp_err", k, resp_err[k], exp_q[k][0].err);
               chk("resp_data", k, resp_data[k], exp_q[k][0].data);
            end else if (!run_m[k]) begin
               chk("resp_err_idle", k, resp_err[k], 1'b0);
               chk("resp_data_idle", k, resp_data[k], 32'h0);
            end
            if (resp_val[k] && resp_rdy[k]) begin
               o.typ  = resp_type[k];
               o.err  = resp_err[k];
               o.data = resp_data[k];
               o.when = cyc;
               obs_q[k].push_back(o);
            end
            acc_s[k] = req_val[k] && er;
            deq_s[k] = ev && resp_rdy[k];
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int k, input logic t, input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit rand_rdy);
      int  waitc;
      bit  got;
      req_val[k]  = 1'b1;
      req_type[k] = t;
      req_addr[k] = a;
      req_data[k] = d;
      req_be[k]   = be;
      waitc = 0;
      do begin
         if (rand_rdy) resp_rdy[k] = 1'($urandom_range(0, 1));
         @(negedge clk);
         got = req_rdy[k];
         @(posedge clk);
         #1;
         waitc++;
      end while (!got && waitc < 200);
      req_val[k] = 1'b0;
      if (!got) chk("accept_timeout", k, 32'd0, 32'd1);
   endtask

   task automatic wait_resp(input int k, input int n);
      int waitc = 0;
      while (obs_q[k].size() < n && waitc < 500) begin
         tick(1);
         waitc++;
      end
      chk("resp_count", k, obs_q[k].size(), n);
   endtask

   task automatic do_reset(input int k);
      int cnt = 0;
      rst_n[k] = 1'b0;
      tick(1);
      chk("rst_resp_val", k, resp_val[k], 1'b0);
      chk("rst_req_rdy", k, req_rdy[k], 1'b0);
      chk("rst_init_done", k, init_done[k], 1'b0);
      rst_n[k] = 1'b1;
      while (!init_done[k] && cnt < 500) begin
         tick(1);
         cnt++;
      end
      chk("init_cycles", k, cnt, N_ENT[k]);
   endtask

   initial begin
      int acc;
      int acc0;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0; req_val[k] = 1'b0; req_type[k] = 1'b0; req_addr[k] = '0;
         req_data[k] = '0; req_be[k] = '0; resp_rdy[k] = 1'b1;
      end
      tick(1);

      // 64-entry, latency 1, depth 2
      do_reset(0);
      obs_q[0].delete();
      send(0, 1'b0, 6'd5, 32'h0, 4'h0, 0);
      wait_resp(0, 1);
      if (obs_q[0].size() >= 1) begin
         chk("rd5_data", 0, obs_q[0][0].data, 32'h0);
         chk("rd5_err", 0, obs_q[0][0].err, 1'b0);
      end

      obs_q[0].delete();
      send(0, 1'b1, 6'd3, 32'hdeadbeef, 4'b1111, 0);
      send(0, 1'b1, 6'd3, 32'h00000011, 4'b0001, 0);
      send(0, 1'b0, 6'd3, 32'h0, 4'h0, 0);
      wait_resp(0, 3);
      if (obs_q[0].size() >= 3) begin
         chk("seq_type0", 0, obs_q[0][0].typ, 1'b1);
         chk("seq_type1", 0, obs_q[0][1].typ, 1'b1);
         chk("seq_type2", 0, obs_q[0][2].typ, 1'b0);
         chk("merge_data", 0, obs_q[0][2].data, 32'hdeadbe11);
      end

      obs_q[0].delete();
      resp_rdy[0] = 1'b0;
      req_val[0] = 1'b1; req_type[0] = 1'b0; req_addr[0] = 6'd3;
      acc = 0;
      repeat (6) begin
         @(negedge clk);
         if (req_rdy[0]) acc++;
         @(posedge clk);
         #1;
      end
      req_val[0] = 1'b0;
      chk("bp_accepts", 0, acc, 2);
      chk("bp_req_rdy", 0, req_rdy[0], 1'b0);
      resp_rdy[0] = 1'b1;
      wait_resp(0, 2);
      tick(2);
      if (obs_q[0].size() >= 2) begin
         chk("drain0_data", 0, obs_q[0][0].data, 32'hdeadbe11);
         chk("drain1_data", 0, obs_q[0][1].data, 32'hdeadbe11);
      end
      chk("drain_req_rdy", 0, req_rdy[0], 1'b1);

      obs_q[0].delete();
      resp_rdy[0] = 1'b0;
      send(0, 1'b0, 6'd5, 32'h0, 4'h0, 0);
      send(0, 1'b0, 6'd3, 32'h0, 4'h0, 0);
      do_reset(0);
      resp_rdy[0] = 1'b1;
      tick(5);
      chk("stale_resp", 0, obs_q[0].size(), 0);
      send(0, 1'b0, 6'd3, 32'h0, 4'h0, 0);
      wait_resp(0, 1);
      if (obs_q[0].size() >= 1) chk("reinit_data", 0, obs_q[0][0].data, 32'h0);

      // 48-entry, latency 2, depth 3
      do_reset(1);
      obs_q[1].delete();
      send(1, 1'b0, 6'd50, 32'h0, 4'h0, 0);
      send(1, 1'b1, 6'd50, 32'hffffffff, 4'hf, 0);
      for (int a = 0; a < 48; a++) send(1, 1'b0, 6'(a), 32'h0, 4'h0, 0);
      wait_resp(1, 50);
      if (obs_q[1].size() >= 50) begin
         chk("oor_rd_err", 1, obs_q[1][0].err, 1'b1);
         chk("oor_rd_data", 1, obs_q[1][0].data, 32'h0);
         chk("oor_wr_err", 1, obs_q[1][1].err, 1'b1);
         for (int a = 0; a < 48; a++) begin
            chk("oor_keep_data", 1, obs_q[1][a+2].data, 32'h0);
            chk("oor_keep_err", 1, obs_q[1][a+2].err, 1'b0);
         end
      end

      obs_q[1].delete();
      for (int a = 0; a < 8; a++) send(1, 1'b1, 6'(a), 32'h10000000 + 32'(a), 4'hf, 0);
      wait_resp(1, 8);
      tick(3);
      obs_q[1].delete();
      send(1, 1'b0, 6'd0, 32'h0, 4'h0, 0);
      acc0 = cyc;
      for (int a = 1; a < 8; a++) send(1, 1'b0, 6'(a), 32'h0, 4'h0, 0);
      wait_resp(1, 8);
      if (obs_q[1].size() >= 8) begin
         chk("lat2_first", 1, obs_q[1][0].when - acc0, 2);
         for (int a = 0; a < 8; a++) begin
            chk("b2b_cycle", 1, obs_q[1][a].when - obs_q[1][0].when, a);
            chk("b2b_data", 1, obs_q[1][a].data, 32'h10000000 + 32'(a));
         end
      end

      // randomized traffic with random response backpressure
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 300; n++) begin
            send(k, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
                 4'($urandom_range(0, 15)), 1);
            if ($urandom_range(0, 3) == 0) tick(1);
         end
         resp_rdy[k] = 1'b1;
         tick(10);
         chk("drained", k, exp_q[k].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
